mem_store_buffer: RTL and testbench

MEM_STORE_BUFFER -- requirements
Module: mem_store_buffer

---
 rtl/mem_store_buffer.sv | 168 ++++++++++++++++
 tb/tb_mem_store_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// Data memory with a FIFO store buffer that retires one store per cycle into the word array.
// Optional macro STORE_FWD_EN: loads merge buffered bytes instead of stalling on a pending match.
module mem_store_buffer #(
  parameter int MEM_WORDS = 4096,
  parameter int SB_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  input  logic                        req_we,
  input  logic [1:0]                  req_width,
  input  logic                        req_sign,
  input  logic [31:0]                 req_addr,
  input  logic [31:0]                 req_wdata,
  input  logic [31:0]                 req_pc,
  input  logic                        drain_req,
  output logic [31:0]                 rdata,
  output logic                        stall,
  output logic                        misalign,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        sb_empty
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   data;
    logic [31:0]   pc;
  } entry_t;

  entry_t        sb_mem [SB_DEPTH];
  logic [31:0]   mem_array [MEM_WORDS];
  logic [PW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg;

  // Held low in normal operation; gives a hook to freeze retirement.
  logic drain_hold;
  assign drain_hold = 1'b0;

  logic [IW-1:0] req_idx;
  logic          unused_addr_bits;
  assign req_idx          = req_addr[IW+1:2];
  assign unused_addr_bits = ^req_addr[31:IW+2];

  logic [3:0]  lane_be;
  logic [31:0] lane_data;
  logic        mis_raw;

  always_comb begin
    lane_be   = 4'b1111;
    lane_data = req_wdata;
    mis_raw   = 1'b0;
    case (req_width)
      2'd1: begin
        lane_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata[15:0]}};
        mis_raw   = req_addr[0];
      end
      2'd2: begin
        lane_be   = 4'b0001 << req_addr[1:0];
        lane_data = {4{req_wdata[7:0]}};
      end
      default: mis_raw = |req_addr[1:0];
    endcase
  end

  // Scan oldest to youngest so younger entries overwrite older bytes.
  logic [31:0]   load_word;
  logic          hit;
  logic [PW-1:0] slot;

  always_comb begin
    load_word = mem_array[req_idx];
    hit       = 1'b0;
    slot      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      slot = head_reg + PW'(i);
      if (i < int'(count_reg) && sb_mem[slot].idx == req_idx) begin
`ifdef STORE_FWD_EN
        for (int b = 0; b < 4; b++) begin
          if (sb_mem[slot].be[b]) load_word[8*b +: 8] = sb_mem[slot].data[8*b +: 8];
        end
`else
        hit = 1'b1;
`endif
      end
    end
  end

  logic [31:0] load_ext;
  logic [31:0] shifted;

  always_comb begin
    shifted  = load_word;
    load_ext = load_word;
    case (req_width)
      2'd1: begin
        shifted  = load_word >> {req_addr[1], 4'b0000};
        load_ext = {{16{req_sign & shifted[15]}}, shifted[15:0]};
      end
      2'd2: begin
        shifted  = load_word >> {req_addr[1:0], 3'b000};
        load_ext = {{24{req_sign & shifted[7]}}, shifted[7:0]};
      end
      default: load_ext = load_word;
    endcase
  end

  logic is_load, is_store, sb_full, sb_busy, do_enq, do_drain;

  assign is_load  = req_valid & ~req_we;
  assign is_store = req_valid & req_we;
  assign sb_full  = (count_reg == CW'(SB_DEPTH));
  assign sb_busy  = (count_reg != '0);

  assign misalign = req_valid & mis_raw;
  assign stall    = req_valid & ~mis_raw &
                    ((drain_req & sb_busy) | (req_we & sb_full) | (~req_we & hit));
  assign rdata    = (is_load & ~mis_raw & ~stall) ? load_ext : 32'h0;
  assign sb_count = count_reg;
  assign sb_empty = ~sb_busy;

  assign do_enq   = is_store & ~mis_raw & ~stall;
  assign do_drain = sb_busy & ~drain_hold;

  entry_t      drain_entry;
  logic [31:0] drain_merged;
  assign drain_entry = sb_mem[head_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign drain_merged[8*gi +: 8] = drain_entry.be[gi] ? drain_entry.data[8*gi +: 8]
                                                           : mem_array[drain_entry.idx][8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int w = 0; w < MEM_WORDS; w++) mem_array[w] <= 32'h0;
    end else begin
      if (do_drain) begin
        mem_array[drain_entry.idx] <= drain_merged;
        head_reg                   <= head_reg + 1'b1;
      end
      if (do_enq) tail_reg <= tail_reg + 1'b1;
      count_reg <= count_reg + CW'(do_enq) - CW'(do_drain);
    end
  end

  // Entry payload needs no reset; occupancy is tracked by count_reg.
  always_ff @(posedge clk) begin
    if (!reset && do_enq) sb_mem[tail_reg] <= '{idx: req_idx, be: lane_be, data: lane_data, pc: req_pc};
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && do_drain)
      $display("@%h: *%h <= %h", drain_entry.pc, 32'({drain_entry.idx, 2'b00}), drain_merged);
  end
`endif
endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: vector table, directed corner sequences, then random traffic vs a byte-level model.
module tb_mem_store_buffer;
  localparam int MEM_WORDS = 4096;
  localparam int SB_DEPTH  = 4;
  localparam int CW        = $clog2(SB_DEPTH) + 1;
  localparam int NBYTES    = 4 * MEM_WORDS;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0, drain_req = 1'b0;
  logic [1:0]    req_width = 2'd0;
  logic [31:0]   req_addr = '0, req_wdata = '0, req_pc = 32'h1000;
  logic [31:0]   rdata;
  logic          stall, misalign, sb_empty;
  logic [CW-1:0] sb_count;

  mem_store_buffer #(.MEM_WORDS(MEM_WORDS), .SB_DEPTH(SB_DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_width(req_width),
    .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .drain_req(drain_req), .rdata(rdata), .stall(stall), .misalign(misalign),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive just after the rising edge, return at the falling edge for sampling.
  task automatic drive(input logic v, input logic we, input logic [1:0] w, input logic s,
                       input logic [31:0] a, input logic [31:0] d, input logic dr);
    @(posedge clk); #1;
    req_valid = v; req_we = we; req_width = w; req_sign = s;
    req_addr = a; req_wdata = d; drain_req = dr; req_pc = req_pc + 4;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; drain_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic v; logic we; logic [1:0] w; logic s;
    logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] exp_rdata; logic exp_stall; logic exp_mis; int exp_cnt;
  } vec_t;

  vec_t vecs[14];

  // ---------------- reference model ----------------
  typedef struct { int unsigned baddr; int nb; logic [31:0] data; } pend_t;
  logic [7:0] ref_bytes [NBYTES];
  pend_t      pend[$];

  function automatic int width_bytes(input logic [1:0] w);
    return (w == 2'd1) ? 2 : (w == 2'd2) ? 1 : 4;
  endfunction

  function automatic logic [7:0] ref_byte(input int unsigned b);
    logic [31:0] t;
    for (int k = pend.size() - 1; k >= 0; k--) begin
      if (b >= pend[k].baddr && b < pend[k].baddr + pend[k].nb) begin
        t = pend[k].data >> (8 * (b - pend[k].baddr));
        return t[7:0];
      end
    end
    return ref_bytes[b];
  endfunction

  function automatic logic [31:0] ref_load(input int unsigned b, input int nb, input logic s);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_byte(b + k);
    if (s && nb == 1) v = {{24{v[7]}}, v[7:0]};
    if (s && nb == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  function automatic bit ref_conflict(input int unsigned b);
    foreach (pend[k]) if ((pend[k].baddr >> 2) == (b >> 2)) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h20, 32'hAABBCCDD, 32'h0,        1'b0, 1'b0, 0};
    vecs[1]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h21, 32'h00000011, 32'h0,        1'b0, 1'b0, 1};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0,  32'h0,        32'h0,        1'b0, 1'b0, 1};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0,  32'h0,        32'h0,        1'b0, 1'b0, 0};
    vecs[4]  = '{1'b1, 1'b0, 2'd2, 1'b1, 32'h21, 32'h0,        32'h00000011, 1'b0, 1'b0, 0};
    vecs[5]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h21, 32'h0,        32'h00000011, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        32'hFFFFAABB, 1'b0, 1'b0, 0};
    vecs[7]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        32'h0000AABB, 1'b0, 1'b0, 0};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'h0,        1'b0, 1'b1, 0};
    vecs[9]  = '{1'b1, 1'b1, 2'd1, 1'b0, 32'h01, 32'hBEEF,     32'h0,        1'b0, 1'b1, 0};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h20, 32'h0,        32'hAABB11DD, 1'b0, 1'b0, 0};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 1'b1, 32'h20, 32'h0,        32'hFFFFFFDD, 1'b0, 1'b0, 0};
    vecs[12] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h00, 32'h0,        32'h00000000, 1'b0, 1'b0, 0};
    vecs[13] = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0,  32'h0,        32'h0,        1'b0, 1'b0, 0};

    do_reset();
    check("reset_count", 32'(sb_count), 32'd0);
    check("reset_empty", 32'(sb_empty), 32'd1);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_misalign", 32'(misalign), 32'd0);
    check("reset_rdata", rdata, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].we, vecs[i].w, vecs[i].s, vecs[i].addr, vecs[i].wdata, 1'b0);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      check($sformatf("vec%0d_misalign", i), 32'(misalign), 32'(vecs[i].exp_mis));
      check($sformatf("vec%0d_count", i), 32'(sb_count), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_empty", i), 32'(sb_empty), 32'(vecs[i].exp_cnt == 0));
    end

    // store then immediate load of the same word
    do_reset();
    drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h10, 32'h12345678, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b0);
`ifdef STORE_FWD_EN
    check("fwd_stall", 32'(stall), 32'd0);
    check("fwd_rdata", rdata, 32'h12345678);
`else
    check("raw_stall", 32'(stall), 32'd1);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b0);
    check("raw_stall_drop", 32'(stall), 32'd0);
    check("raw_rdata", rdata, 32'h12345678);
`endif

    // fill the buffer with retirement frozen
    do_reset();
    force dut.drain_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h40 + 32'(4 * k), 32'hA0 + 32'(k), 1'b0);
      check($sformatf("fill%0d_stall", k), 32'(stall), 32'd0);
    end
    drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h50, 32'hA4, 1'b0);
    check("full_stall", 32'(stall), 32'd1);
    check("full_count", 32'(sb_count), 32'd4);
    release dut.drain_hold;
    drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h50, 32'hA4, 1'b0);
    check("after_full_stall", 32'(stall), 32'd0);
    check("after_full_count", 32'(sb_count), 32'd3);
    begin
      int budget = 20;
      do begin
        idle();
        budget--;
      end while (!sb_empty && budget > 0);
      check("drain_timeout", 32'(sb_empty), 32'd1);
    end
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 1'b0);
    check("fill_first_word", rdata, 32'hA0);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h50, 32'h0, 1'b0);
    check("fill_fifth_word", rdata, 32'hA4);

    // reset discards buffered stores
    do_reset();
    force dut.drain_hold = 1'b1;
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h60 + 32'(4 * k), 32'hDEAD0000 + 32'(k), 1'b0);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 1'b1);
    check("drainreq_stall", 32'(stall), 32'd1);
    check("drainreq_count", 32'(sb_count), 32'd3);
    release dut.drain_hold;
    do_reset();
    check("midreset_count", 32'(sb_count), 32'd0);
    check("midreset_empty", 32'(sb_empty), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h60 + 32'(4 * k), 32'h0, 1'b0);
      check($sformatf("midreset_lw%0d", k), rdata, 32'h0);
    end

    // aliasing addresses wrap onto the same word
    do_reset();
    drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h4, 32'hCAFE0001, 1'b0);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h4 + 32'(NBYTES), 32'hBEEF0002, 1'b0);
    idle();
    idle();
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h4, 32'h0, 1'b0);
    check("wrap_low", rdata, 32'hBEEF0002);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h4 + 32'(NBYTES), 32'h0, 1'b0);
    check("wrap_high", rdata, 32'hBEEF0002);

    // random traffic against the byte-level model
    do_reset();
    foreach (ref_bytes[b]) ref_bytes[b] = 8'h0;
    pend.delete();
    for (int n = 0; n < 400; n++) begin
      logic v, we, s, dr, mis, acc, exp_stall;
      logic [1:0] w;
      logic [31:0] a, d;
      int nb;
      int unsigned b;
      v  = ($urandom % 5) != 0;
      we = $urandom % 2;
      w  = 2'($urandom % 4);
      s  = $urandom % 2;
      dr = ($urandom % 6) == 0;
      d  = $urandom;
      a  = 32'($urandom_range(0, 63));
      if ($urandom % 8 == 0) a = a | ({$urandom} << (2 + $clog2(MEM_WORDS)));
      nb = width_bytes(w);
      if ($urandom % 4 != 0) a = a & ~32'(nb - 1);
      b   = a & (NBYTES - 1);
      mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
      exp_stall = v && !mis && ((dr && pend.size() > 0) || (we && pend.size() == SB_DEPTH)
`ifndef STORE_FWD_EN
                  || (!we && ref_conflict(b))
`endif
                  );
      drive(v, we, w, s, a, d, dr);
      check($sformatf("rnd%0d_stall", n), 32'(stall), 32'(exp_stall));
      check($sformatf("rnd%0d_misalign", n), 32'(misalign), 32'(v && mis));
      check($sformatf("rnd%0d_count", n), 32'(sb_count), 32'(pend.size()));
      check($sformatf("rnd%0d_empty", n), 32'(sb_empty), 32'(pend.size() == 0));
      if (!v) check($sformatf("rnd%0d_idle_rdata", n), rdata, 32'h0);
      else if (!we && !mis && !exp_stall) check($sformatf("rnd%0d_rdata", n), rdata, ref_load(b, nb, s));
      acc = v && we && !mis && !exp_stall;
      if (pend.size() > 0) begin
        for (int k = 0; k < pend[0].nb; k++) begin
          logic [31:0] t;
          t = pend[0].data >> (8 * k);
          ref_bytes[pend[0].baddr + k] = t[7:0];
        end
        void'(pend.pop_front());
      end
      if (acc) pend.push_back('{b, nb, d});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
